// File: rtl/jtkiwi_pkg.sv
// Shared constants for the Kiwi graphics-ROM arbiter: FSM state encoding and owner ids.
package jtkiwi_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_DONE  = 2'd3
   } arb_state_t;

   localparam logic OWN_TM  = 1'b0;
   localparam logic OWN_OBJ = 1'b1;

   localparam int unsigned SETTLE_W = 3;

endpackage

// File: rtl/jtkiwi_arb_pick.sv
// Tie-break between tile map and sprite requests.
// JTKIWI_ARB_TMPRIO_EN selects strict tile-map priority; otherwise round-robin on rr_last.
module jtkiwi_arb_pick
   import jtkiwi_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic tm_cs,
   input  logic obj_cs,
   input  logic done,
   input  logic done_own,
   output logic grant_obj_c
);

`ifdef JTKIWI_ARB_TMPRIO_EN
   logic unused_c;
   assign unused_c    = ^{clk, rst, done, done_own};
   assign grant_obj_c = obj_cs & ~tm_cs;
`else
   logic rr_last;

   // Reset to the sprite so the tile map takes the first tie
   always_ff @(posedge clk) begin
      if (rst)       rr_last <= OWN_OBJ;
      else if (done) rr_last <= done_own;
   end

   assign grant_obj_c = obj_cs & (~tm_cs | ~rr_last);
`endif

endmodule

// File: rtl/jtkiwi_gfx_arb.sv
// Shares the 32-bit graphics ROM slot between the tile map and sprite engines.
// Build option: JTKIWI_ARB_TMPRIO_EN (strict tile-map priority on ties).
module jtkiwi_gfx_arb
   import jtkiwi_pkg::*;
#(
   parameter int unsigned SETTLE = 2,
   parameter int unsigned AW     = 18
)(
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] tm_addr,
   input  logic          tm_cs,
   output logic          tm_ok,
   output logic [31:0]   tm_data,
   input  logic [AW-1:0] obj_addr,
   input  logic          obj_cs,
   output logic          obj_ok,
   output logic [31:0]   obj_data,
   output logic [AW-1:0] rom_addr,
   output logic          rom_cs,
   input  logic          rom_ok,
   input  logic [31:0]   rom_data
);

   arb_state_t           st;
   logic                 own;
   logic [AW-1:0]        lat_addr;
   logic [SETTLE_W-1:0]  cnt;
   logic                 grant_obj_c;
   logic                 own_cs_c;
   logic                 own_hit_c;
   logic                 fetch_done_c;

   assign own_cs_c     = (own == OWN_OBJ) ? obj_cs : tm_cs;
   assign own_hit_c    = own_cs_c && (((own == OWN_OBJ) ? obj_addr : tm_addr) == lat_addr);
   assign fetch_done_c = (st == ARB_WAIT) && own_cs_c && (cnt == '0) && rom_ok;

   // Requester ok holds only while the owner still asks for the fetched address
   assign tm_ok  = (st == ARB_DONE) && (own == OWN_TM)  && own_hit_c;
   assign obj_ok = (st == ARB_DONE) && (own == OWN_OBJ) && own_hit_c;

   jtkiwi_arb_pick u_pick (
      .clk         (clk),
      .rst         (rst),
      .tm_cs       (tm_cs),
      .obj_cs      (obj_cs),
      .done        (fetch_done_c),
      .done_own    (own),
      .grant_obj_c (grant_obj_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         st       <= ARB_IDLE;
         own      <= OWN_TM;
         lat_addr <= '0;
         cnt      <= '0;
         rom_addr <= '0;
         rom_cs   <= 1'b0;
         tm_data  <= '0;
         obj_data <= '0;
      end else begin
         case (st)
            ARB_IDLE: begin
               if (tm_cs || obj_cs) begin
                  own      <= grant_obj_c;
                  lat_addr <= grant_obj_c ? obj_addr : tm_addr;
                  rom_addr <= grant_obj_c ? obj_addr : tm_addr;
                  rom_cs   <= 1'b1;
                  st       <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: begin
               if (!own_cs_c) begin
                  rom_cs <= 1'b0;
                  st     <= ARB_IDLE;
               end else begin
                  cnt <= SETTLE_W'(SETTLE - 1);
                  st  <= ARB_WAIT;
               end
            end
            ARB_WAIT: begin
               // Withdrawal wins over a coincident rom_ok: nothing is captured
               if (!own_cs_c) begin
                  rom_cs <= 1'b0;
                  st     <= ARB_IDLE;
               end else if (cnt != '0) begin
                  cnt <= cnt - SETTLE_W'(1);
               end else if (rom_ok) begin
                  if (own == OWN_OBJ) obj_data <= rom_data;
                  else                tm_data  <= rom_data;
                  rom_cs <= 1'b0;
                  st     <= ARB_DONE;
               end
            end
            ARB_DONE: begin
               if (!own_hit_c) st <= ARB_IDLE;
            end
            default: st <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jtkiwi_gfx_arb.sv
// Randomized self-checking bench for jtkiwi_gfx_arb against a transaction-level timing model.
module tb_jtkiwi_gfx_arb;

   localparam int unsigned SETTLE = 2;
   localparam int unsigned AW     = 18;

   logic          clk;
   logic          rst;
   logic [AW-1:0] tm_addr, obj_addr, rom_addr;
   logic          tm_cs, obj_cs, tm_ok, obj_ok, rom_cs, rom_ok;
   logic [31:0]   tm_data, obj_data, rom_data;

   int   checks = 0;
   int   errors = 0;
   int   cs_age = 0;
   int   lat_cfg = 3;
   logic hold_ok = 1'b0;

   // Reference state: last completed owner, stored data, current owner/address
   logic          rr = 1'b1;
   logic [31:0]   mdl_data [2];
   logic          cur_own = 1'b0;
   logic [AW-1:0] cur_addr = '0;

   jtkiwi_gfx_arb #(.SETTLE(SETTLE), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .tm_addr(tm_addr), .tm_cs(tm_cs), .tm_ok(tm_ok), .tm_data(tm_data),
      .obj_addr(obj_addr), .obj_cs(obj_cs), .obj_ok(obj_ok), .obj_data(obj_data),
      .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data)
   );

   function automatic logic [31:0] data_of(input logic [AW-1:0] a);
      if (a == 18'h00123) return 32'hA5A5_0001;
      return {a[13:0], a} ^ 32'h1357_9BDF;
   endfunction

   // SDRAM slot model: data follows the address, ok comes lat_cfg cycles after cs
   assign rom_data = data_of(rom_addr);
   assign rom_ok   = hold_ok | (rom_cs & (cs_age >= lat_cfg));

   always @(posedge clk) cs_age <= rom_cs ? cs_age + 1 : 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic tie_owner();
`ifdef JTKIWI_ARB_TMPRIO_EN
      return 1'b0;
`else
      return ~rr;
`endif
   endfunction

   // Called in the IDLE cycle where the request is visible (cycle 0); ends in the ok cycle
   task automatic run_fetch(input logic exp_own, input logic [AW-1:0] exp_addr, input int lat);
      int okc;
      okc = ((lat > int'(SETTLE)) ? lat : int'(SETTLE)) + 2;
      for (int k = 1; k <= okc; k++) begin
         step();
         chk("rom_cs", 32'(rom_cs), 32'(k < okc));
         if (k == 1) chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
         chk("tm_ok",  32'(tm_ok),  32'((k == okc) && (exp_own == 1'b0)));
         chk("obj_ok", 32'(obj_ok), 32'((k == okc) && (exp_own == 1'b1)));
      end
      mdl_data[exp_own] = data_of(exp_addr);
      chk("own_data", exp_own ? obj_data : tm_data, mdl_data[exp_own]);
      chk("other_data", exp_own ? tm_data : obj_data, mdl_data[~exp_own]);
      rr       = exp_own;
      cur_own  = exp_own;
      cur_addr = exp_addr;
   endtask

   // Drive a new request set; from_done means the arbiter currently sits in DONE
   task automatic next_req(input logic tcs, input logic ocs, input logic [AW-1:0] ta,
                           input logic [AW-1:0] oa, input int lat, input logic hold,
                           input logic from_done);
      logic [AW-1:0] ta2, oa2;
      logic          eo;
      ta2 = ta;
      oa2 = oa;
      if (from_done && cur_own == 1'b0 && tcs && ta2 == cur_addr) ta2 = ta2 ^ 18'h1;
      if (from_done && cur_own == 1'b1 && ocs && oa2 == cur_addr) oa2 = oa2 ^ 18'h1;
      tm_cs    = tcs;
      obj_cs   = ocs;
      tm_addr  = ta2;
      obj_addr = oa2;
      lat_cfg  = lat;
      hold_ok  = hold;
      if (from_done) begin
         #1;
         chk("ok_drop", 32'(cur_own ? obj_ok : tm_ok), 32'd0);
         step();
      end
      eo = (tcs && ocs) ? tie_owner() : ocs;
      run_fetch(eo, eo ? oa2 : ta2, hold ? 0 : lat);
   endtask

   initial begin
      logic [AW-1:0] ra, rb;
      int            mode;
      mdl_data[0] = '0;
      mdl_data[1] = '0;
      rst = 1'b1; tm_cs = 1'b0; obj_cs = 1'b0; tm_addr = '0; obj_addr = '0;
      step();
      step();
      chk("rst_rom_cs",   32'(rom_cs),   32'd0);
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      chk("rst_tm_ok",    32'(tm_ok),    32'd0);
      chk("rst_obj_ok",   32'(obj_ok),   32'd0);
      chk("rst_tm_data",  tm_data,       32'd0);
      chk("rst_obj_data", obj_data,      32'd0);
      rst = 1'b0;
      step();

      // Single tile map request: rom_ok 3 cycles after rom_cs, ok at cycle 5
      next_req(1'b1, 1'b0, 18'h00123, 18'h0, 3, 1'b0, 1'b0);

      // Stale ok held high: address change drops ok, refetch honours the settle window
      next_req(1'b1, 1'b0, 18'h00124, 18'h0, 0, 1'b1, 1'b1);

      // Random mix of single and tied requests, latencies and held ok
      for (int i = 0; i < 40; i++) begin
         mode = $urandom_range(0, 2);
         ra   = AW'($urandom);
         rb   = AW'($urandom);
         next_req(mode != 1, mode != 0, ra, rb, $urandom_range(0, 6),
                  $urandom_range(0, 3) == 0, 1'b1);
      end

      // Force a tile map completion so a later tie would favour the sprite
      next_req(1'b1, 1'b0, 18'h01000, 18'h0, 1, 1'b0, 1'b1);

      // Sprite withdraws during WAIT
      tm_cs = 1'b0; obj_cs = 1'b1; obj_addr = 18'h2AAAA; lat_cfg = 6; hold_ok = 1'b0;
      #1;
      chk("wd_ok_drop", 32'(tm_ok), 32'd0);
      step();
      step();
      step();
      chk("wd_rom_cs_wait", 32'(rom_cs), 32'd1);
      obj_cs = 1'b0;
      step();
      chk("wd_rom_cs", 32'(rom_cs), 32'd0);
      chk("wd_obj_ok", 32'(obj_ok), 32'd0);
      chk("wd_obj_data", obj_data, mdl_data[1]);

      // Reset pulsed during WAIT of a fresh sprite fetch
      obj_cs = 1'b1;
      step();
      step();
      rst = 1'b1; obj_cs = 1'b0;
      step();
      chk("mr_rom_cs",   32'(rom_cs), 32'd0);
      chk("mr_tm_ok",    32'(tm_ok),  32'd0);
      chk("mr_obj_ok",   32'(obj_ok), 32'd0);
      chk("mr_obj_data", obj_data,    32'd0);
      mdl_data[0] = '0;
      mdl_data[1] = '0;
      rr = 1'b1;
      rst = 1'b0;

      // Ties from reset: four fetches, then the tile map stops requesting
      next_req(1'b1, 1'b1, 18'h00400, 18'h00800, 2, 1'b0, 1'b0);
      chk("tie_first_tm", 32'(tm_ok), 32'd1);
      for (int i = 0; i < 3; i++)
         next_req(1'b1, 1'b1, AW'($urandom), AW'($urandom), $urandom_range(0, 4), 1'b0, 1'b1);
      next_req(1'b0, 1'b1, 18'h0, AW'($urandom), 2, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/jtkiwi_gfx_arb.md
# jtkiwi_gfx_arb

Graphics-ROM arbiter for the Kiwi video subsystem. It shares the single 32-bit graphics ROM port between the tile map drawing engine and the sprite (object) drawing engine. Each requester sees a private ROM interface. The arbiter sequences one fetch at a time toward the SDRAM slot, masks stale `ok` after address changes, and returns the fetched word to the granted requester.

## Interface
Parameters:
- `SETTLE`, 2: cycles after a new `rom_addr` is issued during which `rom_ok` is ignored (range 1–7).
- `AW`, 18: ROM word-address width (bits [19:2]).

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `tm_addr`  in  AW  tile map word address.
- `tm_cs`  in  1  tile map request.
- `tm_ok`  out  1  tile map data valid.
- `tm_data`  out  32  tile map data.
- `obj_addr`  in  AW  sprite word address.
- `obj_cs`  in  1  sprite request.
- `obj_ok`  out  1  sprite data valid.
- `obj_data`  out  32  sprite data.
- `rom_addr`  out  AW  address to the SDRAM slot.
- `rom_cs`  out  1  request to the SDRAM slot.
- `rom_ok`  in  1  SDRAM data valid for `rom_addr`.
- `rom_data`  in  32  SDRAM data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset enters IDLE. Owner register `own` (0 = tile map, 1 = sprite).
- **IDLE**
  - If exactly one `*_cs` is high, grant that requester.
  - If both are high, grant per the priority rule (see Configuration).
  - Latch the granted address into `lat_addr`. Go to ISSUE.
- **ISSUE**
  - Drive `rom_addr = lat_addr` and `rom_cs = 1`.
  - Load the settle counter with `SETTLE-1`. Go to WAIT.
- **WAIT**
  - Keep `rom_cs = 1`.
  - Decrement the settle counter to 0. While it is non-zero, ignore `rom_ok`.
  - When the counter is 0 and `rom_ok = 1`:
    - Capture `rom_data` into the owner's data register.
    - Drop `rom_cs`.
    - Set the `round-robin last` bit `rr_last = own`.
    - Go to DONE.
- **DONE**
  - Owner ok (combinational): `own_cs & (own_addr == lat_addr)`.
  - When that term becomes 0 (cs dropped or address changed), return to IDLE next cycle. If a new request is pending, it is evaluated in that IDLE cycle.
- Withdrawal: if the owner drops `cs` during ISSUE or WAIT, drop `rom_cs` next cycle and return to IDLE. No data is captured.
- The non-owner's ok is always 0.
- Data registers hold their last captured value and are not cleared by a new grant.

## Timing
- Reset values:
  - Outputs: `rom_cs = 0`, `rom_addr = 0`, `tm_ok = 0`, `obj_ok = 0`, `tm_data = 0`, `obj_data = 0`.
  - Internal: state IDLE, `rr_last = 1`, so the tile map wins the first tie.
- Latency:
  - cs seen in IDLE (cycle 0) → `rom_cs` high at cycle 1.
  - `rom_ok` is sampled from cycle `1+SETTLE` onward.
  - Requester ok rises the cycle after the accepted `rom_ok`.
  - Minimum request-to-ok is `SETTLE+2` cycles.
- Back-to-back from one requester: after the address changes, ok falls in the same cycle. One IDLE cycle follows, then the next ISSUE.
- A `rom_ok` arriving while the counter is non-zero is discarded, even if it stays high into the sampled window. It is re-sampled only from the window onward.
- A reset asserted in any state takes effect on the next edge: IDLE, `rom_cs = 0`, both oks 0, a pending fetch abandoned.

## Configuration
- `JTKIWI_ARB_TMPRIO_EN` defined: strict priority. The tile map wins every tie, and `rr_last` is unused.
- Not defined: round-robin. On a tie the grant goes to `~rr_last`, and `rr_last` updates on each completed fetch.
- Either way, a single pending requester is granted immediately.

## Structure
- Shared package `jtkiwi_pkg`:
  - state encoding constants `ARB_IDLE`, `ARB_ISSUE`, `ARB_WAIT`, `ARB_DONE`;
  - owner constants `OWN_TM = 0`, `OWN_OBJ = 1`.
- One sub-module, `jtkiwi_arb_pick`, holds the tie-break and `rr_last` logic. It is the only place the macro is tested.
- Everything else is flat in `jtkiwi_gfx_arb`.

## Test plan
- Single request: tile map `tm_addr = 18'h00123`, `SETTLE = 2`, and the model asserts `rom_ok` 3 cycles after `rom_cs` with data `32'hA5A5_0001`. Required: `rom_addr = 18'h00123`; `tm_ok` rises at cycle 5 with `tm_data = 32'hA5A5_0001`; `obj_ok` stays 0.
- Stale ok: the model holds `rom_ok = 1` continuously. Required: the first grant completes no earlier than cycle 4. After an address change, `tm_ok` drops the same cycle and rises again no earlier than 4 cycles later.
- Tie, macro off: both cs are high from reset for 4 fetches. Required grant order: tm, obj, tm, obj.
- Tie, macro on: same stimulus. Required: all 4 grants go to the tile map while it keeps requesting. `obj_ok` rises only after `tm_cs` drops.
- Withdrawal: `obj_cs` drops during WAIT. Required: `rom_cs` is 0 next cycle, `obj_data` is unchanged, and the state returns to IDLE.
- Mid-fetch reset: `rst` is pulsed during WAIT. Required: the next cycle shows `rom_cs = 0` and both oks 0; the first tie after reset goes to the tile map.
